// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one registered WIDTH-bit adder among NUM_REQ requesters.
// Each transaction is accepted, added, and then returned with its requester ID over a valid/ready response port.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   next_ptr;
    logic              grant_found;
    logic [WIDTH-1:0]  cap_a;
    logic [WIDTH-1:0]  cap_b;
    logic [ID_W-1:0]   cap_id;

    // First valid requester at or after ptr, wrapping around the requester ring.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Gated by rst_n so no grant is visible while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        cap_a  <= req_a[grant_id*WIDTH +: WIDTH];
                        cap_b  <= req_b[grant_id*WIDTH +: WIDTH];
                        cap_id <= grant_id;
                        ptr    <= next_ptr;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    {rsp_carry, rsp_sum} <= {1'b0, cap_a} + {1'b0, cap_b};
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Result fields are left in place after the handshake; only valid drops.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
